// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with an internal synchronous-read data RAM feeding the MEM/WB register.
// Latency: 1 cycle for non-loads, 2 cycles for loads (registered RAM read).
// Backpressure: mstall pulses for one cycle on each accepted load; inputs are ignored in the following cycle.
// Optional feature macro MEM_ALIGN_CHECK_EN: misaligned accesses are suppressed and set a sticky misalign flag.
module mem_stage #(
  parameter int AW = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [4:0]  mrd,
  input  logic [31:0] mr,
  input  logic [31:0] mqb,
  output logic        mstall,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [4:0]  wrd,
  output logic [31:0] wr,
  output logic [31:0] wmo,
  output logic        misalign
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state;
  logic [31:0]   ram [0:(1<<AW)-1];
  logic [31:0]   rdata;
  logic [AW-1:0] idx;
  logic          misaligned;
  logic          load_go;
  logic          ram_we;

  // Load bookkeeping held across the wait cycle
  logic          lat_wreg;
  logic [4:0]    lat_rd;
  logic [31:0]   lat_r;

  assign idx = mr[AW+1:2];

  // A load is only accepted from IDLE; the illegal load+store combination counts as a load
  assign load_go = (state == S_IDLE) && mm2reg && !misaligned;
  // Stores never write while a load is in flight or when the pair is load+store
  assign ram_we  = !reset && (state == S_IDLE) && mwmem && !mm2reg && !misaligned;
  assign mstall  = !reset && load_go;

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q;

  assign misaligned = |mr[1:0];

  // Sticky misaligned-access flag, only cleared by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      misalign_q <= 1'b0;
    else if ((state == S_IDLE) && (mwmem || mm2reg) && misaligned)
      misalign_q <= 1'b1;
  end

  assign misalign = misalign_q;
`else
  logic unused_low_addr;

  assign misaligned      = 1'b0;
  assign misalign        = 1'b0;
  assign unused_low_addr = ^mr[1:0];
`endif

  // Data RAM: write-first ordering is not needed since a read and a write never share a cycle
  always_ff @(posedge clock) begin
    if (ram_we)
      ram[idx] <= mqb;
    if (load_go)
      rdata <= ram[idx];
  end

  // Stage control and MEM/WB register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wwreg    <= 1'b0;
      wm2reg   <= 1'b0;
      wrd      <= 5'd0;
      wr       <= 32'd0;
      wmo      <= 32'd0;
      lat_wreg <= 1'b0;
      lat_rd   <= 5'd0;
      lat_r    <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mm2reg) begin
            // Loads (and suppressed misaligned loads) push a bubble into MEM/WB
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
            wrd    <= 5'd0;
            wr     <= 32'd0;
            wmo    <= 32'd0;
            if (!misaligned) begin
              lat_wreg <= mwreg;
              lat_rd   <= mrd;
              lat_r    <= mr;
              state    <= S_WAIT;
            end
          end else begin
            wwreg  <= mwreg;
            wm2reg <= mm2reg;
            wrd    <= mrd;
            wr     <= mr;
            wmo    <= 32'd0;
          end
        end
        S_WAIT: begin
          wwreg  <= lat_wreg;
          wm2reg <= 1'b1;
          wrd    <= lat_rd;
          wr     <= lat_r;
          wmo    <= rdata;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed test-plan scenarios plus randomized instruction stream for mem_stage.
// Outputs compared every cycle against a queue/array model, with literal spot checks.
// Build with MEM_ALIGN_CHECK_EN defined to exercise the alignment-check variant.
module tb_mem_stage;
  localparam int AW = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mwreg = 1'b0, mm2reg = 1'b0, mwmem = 1'b0;
  logic [4:0]  mrd = 5'd0;
  logic [31:0] mr = 32'd0, mqb = 32'd0;
  logic        mstall, wwreg, wm2reg, misalign;
  logic [4:0]  wrd;
  logic [31:0] wr, wmo;

  int vectors = 0;
  int errors  = 0;
  bit run     = 1'b0;

  mem_stage #(.AW(AW)) dut (
    .clock(clock), .reset(reset), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .mrd(mrd), .mr(mr), .mqb(mqb), .mstall(mstall), .wwreg(wwreg), .wm2reg(wm2reg),
    .wrd(wrd), .wr(wr), .wmo(wmo), .misalign(misalign)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  typedef struct {
    logic        wreg;
    logic [4:0]  rd;
    logic [31:0] r;
    logic [31:0] d;
  } pend_t;

  pend_t       pq[$];
  logic [31:0] mdl_mem [0:(1<<AW)-1];
  logic        e_wwreg = 1'b0, e_wm2reg = 1'b0, e_mis = 1'b0;
  logic [4:0]  e_wrd = 5'd0;
  logic [31:0] e_wr = 32'd0, e_wmo = 32'd0;

  function automatic logic is_mis(input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pq.delete();
      {e_wwreg, e_wm2reg, e_mis} = 3'b000;
      e_wrd = 5'd0; e_wr = 32'd0; e_wmo = 32'd0;
    end else if (pq.size() > 0) begin
      pend_t p;
      p = pq.pop_front();
      e_wwreg = p.wreg; e_wm2reg = 1'b1; e_wrd = p.rd; e_wr = p.r; e_wmo = p.d;
    end else begin
      if ((mwmem || mm2reg) && is_mis(mr)) e_mis = 1'b1;
      if (mm2reg) begin
        e_wwreg = 1'b0; e_wm2reg = 1'b0; e_wrd = 5'd0; e_wr = 32'd0; e_wmo = 32'd0;
        if (!is_mis(mr)) pq.push_back('{mwreg, mrd, mr, mdl_mem[mr[AW+1:2]]});
      end else begin
        e_wwreg = mwreg; e_wm2reg = 1'b0; e_wrd = mrd; e_wr = mr; e_wmo = 32'd0;
        if (mwmem && !is_mis(mr)) mdl_mem[mr[AW+1:2]] = mqb;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge
  always @(negedge clock) begin
    if (run) begin
      chk("mstall", {31'd0, mstall},
          {31'd0, !reset && pq.size() == 0 && mm2reg && !is_mis(mr)});
      chk("wwreg",    {31'd0, wwreg},    {31'd0, e_wwreg});
      chk("wm2reg",   {31'd0, wm2reg},   {31'd0, e_wm2reg});
      chk("wrd",      {27'd0, wrd},      {27'd0, e_wrd});
      chk("wr",       wr,                e_wr);
      chk("wmo",      wmo,               e_wmo);
      chk("misalign", {31'd0, misalign}, {31'd0, e_mis});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic w, input logic m2r, input logic wm,
                       input logic [4:0] rd, input logic [31:0] r, input logic [31:0] q);
    mwreg = w; mm2reg = m2r; mwmem = wm; mrd = rd; mr = r; mqb = q;
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic nop;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b0, 1'b1, 5'd0, a, d);
    step();
  endtask

  // Load held for its stall cycle as the upstream pipeline would, then a nop
  task automatic load_nop(input logic [4:0] rd, input logic [31:0] a);
    drive(1'b1, 1'b1, 1'b0, rd, a, 32'd0);
    step();
    step();
    nop();
  endtask

  initial begin
    // Reset takes effect immediately
    #1 reset = 1'b1;
    #1;
    chk("rst_wwreg",  {31'd0, wwreg},  32'd0);
    chk("rst_wr",     wr,              32'd0);
    chk("rst_wmo",    wmo,             32'd0);
    chk("rst_mstall", {31'd0, mstall}, 32'd0);
    run = 1'b1;
    step();
    reset = 1'b0;

    // Preload the first 32 words so every later load reads known data
    for (int i = 0; i < 32; i++) store({23'd0, i[6:0], 2'b00}, $urandom);

    // ALU op
    drive(1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'd0);
    step();
    chk("alu_wwreg", {31'd0, wwreg}, 32'd1);
    chk("alu_wrd",   {27'd0, wrd},   32'd5);
    chk("alu_wr",    wr,             32'h1234);
    chk("alu_wmo",   wmo,            32'd0);

    // Reset mid-stream, then the ALU op again
    drive(1'b1, 1'b0, 1'b0, 5'd7, 32'h55, 32'd0);
    step();
    reset = 1'b1;
    #1;
    chk("mid_rst_wwreg", {31'd0, wwreg}, 32'd0);
    chk("mid_rst_wrd",   {27'd0, wrd},   32'd0);
    chk("mid_rst_wr",    wr,             32'd0);
    step();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'd0);
    step();
    chk("alu2_wrd", {27'd0, wrd}, 32'd5);
    chk("alu2_wr",  wr,           32'h1234);

    // Store then load of the same word
    store(32'h10, 32'hDEADBEEF);
    drive(1'b1, 1'b1, 1'b0, 5'd8, 32'h10, 32'd0);
    #1 chk("ld_stall_on", {31'd0, mstall}, 32'd1);
    step();
    chk("ld_stall_off", {31'd0, mstall}, 32'd0);
    chk("ld_bubble",    {31'd0, wwreg},  32'd0);
    step();
    nop();
    chk("ld_wwreg",  {31'd0, wwreg},  32'd1);
    chk("ld_wm2reg", {31'd0, wm2reg}, 32'd1);
    chk("ld_wrd",    {27'd0, wrd},    32'd8);
    chk("ld_wmo",    wmo,             32'hDEADBEEF);

    // Back-to-back loads
    store(32'h20, 32'h1);
    store(32'h24, 32'h2);
    drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h20, 32'd0);
    step();
    chk("b2b_wait_stall", {31'd0, mstall}, 32'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h24, 32'd0);
    #1;
    chk("b2b_wmo1",   wmo,             32'h1);
    chk("b2b_stall2", {31'd0, mstall}, 32'd1);
    step();
    step();
    nop();
    chk("b2b_wmo2", wmo, 32'h2);

    // Load followed by store to the same word, then reload
    store(32'h30, 32'h5);
    drive(1'b1, 1'b1, 1'b0, 5'd6, 32'h30, 32'd0);
    step();
    step();
    chk("ld_st_old", wmo, 32'h5);
    store(32'h30, 32'h9);
    load_nop(5'd6, 32'h30);
    chk("ld_st_new", wmo, 32'h9);

    // Reset during the wait cycle abandons the load
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h30, 32'd0);
    step();
    reset = 1'b1;
    #1;
    chk("wait_rst_wwreg", {31'd0, wwreg}, 32'd0);
    nop();
    step();
    reset = 1'b0;
    #1 chk("wait_rst_stall", {31'd0, mstall}, 32'd0);
    step();
    chk("wait_rst_nowb", {31'd0, wwreg}, 32'd0);

    // Alignment handling
    store(32'h40, 32'h77);
    store(32'h41, 32'hAA);
    load_nop(5'd10, 32'h40);
`ifdef MEM_ALIGN_CHECK_EN
    chk("align_word",   wmo,               32'h77);
    chk("align_flag",   {31'd0, misalign}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 5'd11, 32'h42, 32'd0);
    #1 chk("mis_ld_stall", {31'd0, mstall}, 32'd0);
    step();
    nop();
    chk("mis_ld_bubble", {31'd0, wwreg}, 32'd0);
    step();
    chk("align_sticky", {31'd0, misalign}, 32'd1);
`else
    chk("align_word", wmo,               32'hAA);
    chk("align_flag", {31'd0, misalign}, 32'd0);
`endif

    // Randomized instruction stream with occasional reset pulses
    for (int n = 0; n < 3000; n++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a = {$urandom_range(0, 32'h3FFFFF) & 32'h3FFFFF, 10'd0}
          | {23'd0, 5'($urandom_range(0, 31)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) reset = 1'b1;
      case (kind)
        0, 1, 2, 3: drive(1'($urandom), 1'b0, 1'b0, 5'($urandom), $urandom, $urandom);
        4, 5:       drive(1'($urandom), 1'b0, 1'b1, 5'($urandom), a, $urandom);
        6, 7:       drive(1'($urandom), 1'b1, 1'b0, 5'($urandom), a, $urandom);
        8:          drive(1'($urandom), 1'b1, 1'b1, 5'($urandom), a, $urandom);
        default:    nop();
      endcase
      step();
      reset = 1'b0;
    end

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
